mips_muldiv_unit: RTL and testbench
===================================

MIPS_MULDIV_UNIT -- requirements
Module: mips_muldiv_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand width and the width of each of HI and LO; legal values are 4 to 64.
REQ-002 The block SHALL have input clk, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have input reset, 1 bit: synchronous, active-low reset.
REQ-004 The block SHALL have input start, 1 bit: request a new operation.
REQ-005 The block SHALL have input op, 2 bits: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 The block SHALL have inputs operand_a and operand_b, WIDTH bits each: rs (multiplicand or dividend) and rt (multiplier or divisor).
REQ-007 The block SHALL have input flush, 1 bit: abort any in-flight operation.
REQ-008 The block SHALL have inputs hi_we and lo_we, 1 bit each, and input wdata, WIDTH bits: the MTHI and MTLO write path.
REQ-009 The block SHALL have output busy, 1 bit: an operation is in flight, and the pipeline stalls any MFHI or MFLO.
REQ-010 The block SHALL have output done, 1 bit: a one-cycle pulse marking the result update.
REQ-011 The block SHALL have output div_by_zero, 1 bit: qualifies done for a DIV or DIVU with a zero divisor.
REQ-012 The block SHALL have outputs hi and lo, WIDTH bits each: the architectural HI and LO registers.

Function
REQ-013 The block SHALL implement the FSM states IDLE, CALC and FIX.
REQ-014 The block SHALL accept start only in IDLE; the start edge is E0, at which op and the operands are captured and the FSM moves to CALC with iteration counter = WIDTH-1.
REQ-015 The block SHALL ignore start while busy, with no queueing.
REQ-016 For multiply, the block SHALL perform one shift-add iteration per CALC edge on unsigned magnitudes.
REQ-017 For divide, the block SHALL perform one restoring-division iteration per CALC edge on unsigned magnitudes.
REQ-018 CALC SHALL last exactly WIDTH edges (E1..E_WIDTH) and then move to FIX.
REQ-019 At edge E(WIDTH+1) the block SHALL apply sign correction, write HI and LO, assert done for exactly one cycle, clear busy and return to IDLE.
REQ-020 busy SHALL read 1 from after E0 until E(WIDTH+1); fixed latency, independent of operand values.
REQ-021 MULT SHALL give the signed two's-complement 2*WIDTH-bit product and MULTU the unsigned product, with HI = upper half and LO = lower half.
REQ-022 DIV SHALL give LO = quotient truncated toward zero and HI = remainder carrying the sign of the dividend; DIVU SHALL give the unsigned quotient and remainder.
REQ-023 For DIV with the most-negative dividend and a divisor of -1, the block SHALL give LO = most-negative value and HI = 0, with no other flag.
REQ-024 For a divisor of zero (DIV or DIVU), the block SHALL give HI = operand_a and LO = all ones, assert div_by_zero together with done, and take the full latency.
REQ-025 div_by_zero SHALL be 0 in every cycle in which done is 0.
REQ-026 In IDLE without start, hi_we SHALL load hi <= wdata and lo_we SHALL load lo <= wdata; both may be asserted in the same cycle.
REQ-027 When start and hi_we or lo_we coincide in IDLE, start SHALL win and the write SHALL be dropped.
REQ-028 hi_we and lo_we SHALL be ignored while busy.
REQ-029 flush SHALL return the FSM to IDLE at the next edge in any state, leaving HI and LO unchanged and producing no done.
REQ-030 flush together with start in IDLE SHALL discard the start.
REQ-031 flush SHALL take priority over the FIX write.
REQ-032 hi and lo SHALL change only at a FIX edge, an accepted MTHI or MTLO, or reset.

Reset
REQ-033 When reset = 0 at a rising edge, the block SHALL set hi = 0, lo = 0, busy = 0, done = 0 and div_by_zero = 0, with the FSM in IDLE and the counter at 0.
REQ-034 Reset SHALL override start, flush and the write inputs.
REQ-035 Reset during CALC or FIX SHALL abort the operation with no done pulse.

Verification (WIDTH=32)
REQ-036 The bench SHALL check MULT a=0xFFFFFFFF, b=0x00000002 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE, done exactly at E33, busy high for 33 cycles.
REQ-037 The bench SHALL check MULTU with the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
REQ-038 The bench SHALL check DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; then DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-039 The bench SHALL check DIVU a=7, b=0 -> hi=0x00000007, lo=0xFFFFFFFF, div_by_zero=1 for the single done cycle.
REQ-040 The bench SHALL check: preload hi=0x1234 via hi_we, start MULTU, assert flush at E10 -> busy=0 after E10, no done, hi=0x1234; a second start pulsed during busy is ignored.
REQ-041 The bench SHALL check reset=0 at E5 of a DIV -> all outputs 0 next cycle; a subsequent MULTU 3*5 -> lo=15, hi=0.

Source files
------------

// File: rtl/mips_muldiv_if.sv
`default_nettype none
// ============================================================================
// Module   : mips_muldiv_if
// Purpose  : Bundles the operation request, MTHI/MTLO write path and the
//            HI/LO result bus of the MIPS multiply/divide unit.
// Revision : 1.0 - initial release
// ============================================================================
interface mips_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             flush;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  // Pipeline side: issues operations and register writes, reads results
  modport master (
    output start, op, operand_a, operand_b, flush, hi_we, lo_we, wdata,
    input  busy, done, div_by_zero, hi, lo
  );

  // Unit side
  modport slave (
    input  start, op, operand_a, operand_b, flush, hi_we, lo_we, wdata,
    output busy, done, div_by_zero, hi, lo
  );
endinterface
`default_nettype wire

// File: rtl/mips_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : mips_muldiv_unit
// Purpose  : Iterative MIPS MULT/MULTU/DIV/DIVU unit with architectural HI/LO.
//            One shift-add or restoring-division step per cycle on operand
//            magnitudes, followed by a single sign-correction cycle, giving a
//            fixed WIDTH+1 cycle latency.
// Revision : 1.0 - initial release
// ============================================================================
module mips_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  wire logic     clk,
  input  wire logic     reset,
  mips_muldiv_if.slave  bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] C_CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t           state_q,  state_d;
  logic [CW-1:0]    cnt_q,    cnt_d;
  // Multiply: {partial product, multiplier}. Divide: {remainder, quotient}.
  logic [2*WIDTH-1:0] acc_q,  acc_d;
  // Multiplicand magnitude (multiply) or divisor magnitude (divide)
  logic [WIDTH-1:0] dvs_q,    dvs_d;
  logic [WIDTH-1:0] a_raw_q,  a_raw_d;
  logic             is_div_q, is_div_d;
  logic             neg_lo_q, neg_lo_d;   // negate product / quotient
  logic             neg_hi_q, neg_hi_d;   // negate remainder
  logic             dbz_q,    dbz_d;      // divisor was zero
  logic [WIDTH-1:0] hi_q,     hi_d;
  logic [WIDTH-1:0] lo_q,     lo_d;
  logic             done_q,   done_d;
  logic             dbzo_q,   dbzo_d;

  logic             w_signed_op;
  logic             w_div_op;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic [WIDTH:0]   w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_trial;
  logic [2*WIDTH-1:0] w_div_next;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0] w_quo_fix;
  logic [WIDTH-1:0] w_rem_fix;

  // Operand magnitudes and single-step datapath for multiply and divide
  always_comb begin
    w_signed_op = ~bus.op[0];
    w_div_op    = bus.op[1];
    w_mag_a     = (w_signed_op && bus.operand_a[WIDTH-1]) ?
                  (WIDTH'(0) - bus.operand_a) : bus.operand_a;
    w_mag_b     = (w_signed_op && bus.operand_b[WIDTH-1]) ?
                  (WIDTH'(0) - bus.operand_b) : bus.operand_b;

    // Shift-add: conditionally add multiplicand into the upper half, then
    // shift the whole accumulator right, consuming one multiplier bit.
    w_mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, dvs_q};
    w_mul_next = acc_q[0] ? {w_mul_sum, acc_q[WIDTH-1:1]}
                          : {1'b0, acc_q[2*WIDTH-1:1]};

    // Restoring division: shift in the next dividend bit, try subtracting
    // the divisor and keep the difference only if it did not go negative.
    w_rem_sh = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    w_trial  = w_rem_sh - {1'b0, dvs_q};
    if (!w_trial[WIDTH]) begin
      w_div_next = {w_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      w_div_next = {w_rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end

    // Sign correction applied in FIX
    w_prod_fix = neg_lo_q ? ((2*WIDTH)'(0) - acc_q) : acc_q;
    w_quo_fix  = neg_lo_q ? (WIDTH'(0) - acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
    w_rem_fix  = neg_hi_q ? (WIDTH'(0) - acc_q[2*WIDTH-1:WIDTH])
                          : acc_q[2*WIDTH-1:WIDTH];
  end

  // Next-state and register-update logic; flush beats everything but reset
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    dvs_d    = dvs_q;
    a_raw_d  = a_raw_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    dbz_d    = dbz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    dbzo_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          // A start always suppresses a coincident MTHI/MTLO; a coincident
          // flush discards the start itself.
          if (!bus.flush) begin
            state_d  = S_CALC;
            cnt_d    = C_CNT_LAST;
            is_div_d = w_div_op;
            a_raw_d  = bus.operand_a;
            acc_d    = w_div_op ? {WIDTH'(0), w_mag_a} : {WIDTH'(0), w_mag_b};
            dvs_d    = w_div_op ? w_mag_b : w_mag_a;
            neg_lo_d = w_signed_op & (bus.operand_a[WIDTH-1] ^ bus.operand_b[WIDTH-1]);
            neg_hi_d = w_signed_op & bus.operand_a[WIDTH-1];
            dbz_d    = w_div_op & (bus.operand_b == WIDTH'(0));
          end
        end else begin
          if (bus.hi_we) hi_d = bus.wdata;
          if (bus.lo_we) lo_d = bus.wdata;
        end
      end

      S_CALC: begin
        acc_d = is_div_q ? w_div_next : w_mul_next;
        if (cnt_q == CW'(0)) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      S_FIX: begin
        state_d = S_IDLE;
        cnt_d   = CW'(0);
        done_d  = 1'b1;
        dbzo_d  = dbz_q;
        if (dbz_q) begin
          hi_d = a_raw_q;
          lo_d = '1;
        end else if (is_div_q) begin
          hi_d = w_rem_fix;
          lo_d = w_quo_fix;
        end else begin
          hi_d = w_prod_fix[2*WIDTH-1:WIDTH];
          lo_d = w_prod_fix[WIDTH-1:0];
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = CW'(0);
      end
    endcase

    if (bus.flush && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      cnt_d   = CW'(0);
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      dbzo_d  = 1'b0;
    end
  end

  // State and data registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      dvs_q    <= '0;
      a_raw_q  <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      dbz_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dbzo_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      dvs_q    <= dvs_d;
      a_raw_q  <= a_raw_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      dbz_q    <= dbz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      dbzo_q   <= dbzo_d;
    end
  end

  assign bus.busy        = (state_q != S_IDLE);
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbzo_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_muldiv_unit
// Purpose  : Scoreboard bench for mips_muldiv_unit (WIDTH = 32). Stimulus
//            pushes expected results; a monitor pops them on every done.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_muldiv_unit;

  localparam int W   = 32;
  localparam int LAT = W + 1;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    int           due;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   compared;
  int   mismatched;
  exp_t sb_q[$];
  logic [W-1:0] model_hi;
  logic [W-1:0] model_lo;

  mips_muldiv_if #(.WIDTH(W)) bus ();

  mips_muldiv_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] ex);
    compared++;
    if (act !== ex) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", nm, act, ex, cyc);
    end
  endtask

  // Reference model: plain signed/unsigned 64-bit arithmetic
  task automatic model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] h, output logic [W-1:0] l, output logic z);
    longint          sa;
    longint          sb;
    longint unsigned ua;
    longint unsigned ub;
    logic [63:0]     p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    z  = 1'b0;
    p  = '0;
    h  = '0;
    l  = '0;
    case (op)
      2'b00: begin p = sa * sb; h = p[63:32]; l = p[31:0]; end
      2'b01: begin p = ua * ub; h = p[63:32]; l = p[31:0]; end
      default: begin
        if (b == '0) begin
          h = a; l = '1; z = 1'b1;
        end else if (op == 2'b10) begin
          p = sa / sb; l = p[31:0];
          p = sa % sb; h = p[31:0];
        end else begin
          p = ua / ub; l = p[31:0];
          p = ua % ub; h = p[31:0];
        end
      end
    endcase
  endtask

  // Monitor: pop and compare on every done; div_by_zero must be 0 otherwise
  always @(negedge clk) begin
    exp_t e;
    if (bus.done) begin
      if (sb_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_done: got done=1 required done=0 (cycle %0d)", cyc);
      end else begin
        e = sb_q.pop_front();
        chk("result_hi",   bus.hi,          e.hi);
        chk("result_lo",   bus.lo,          e.lo);
        chk("div_by_zero", bus.div_by_zero, e.dbz);
        chk("done_cycle",  cyc,             e.due);
      end
    end else begin
      chk("dbz_without_done", bus.div_by_zero, 1'b0);
    end
  end

  function automatic logic [W-1:0] rand_val();
    case ($urandom_range(0, 6))
      0:       return '0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'd1;
      4:       return 32'(signed'($urandom_range(0, 20)) - 10);
      default: return $urandom;
    endcase
  endfunction

  // Issue one operation and run it to completion.
  // disturb: mid-flight start and MTHI/MTLO that must both be ignored.
  // we_at_start: MTHI/MTLO coincident with start, which must be dropped.
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eh, input logic [W-1:0] el, input logic ez,
                        input bit chk_busy, input bit disturb, input bit we_at_start);
    int   n;
    exp_t e;
    bus.op        = op;
    bus.operand_a = a;
    bus.operand_b = b;
    bus.start     = 1'b1;
    bus.hi_we     = we_at_start;
    bus.lo_we     = we_at_start;
    bus.wdata     = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.start = 1'b0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    e.hi  = eh;
    e.lo  = el;
    e.dbz = ez;
    e.due = cyc + LAT;
    sb_q.push_back(e);
    if (we_at_start) begin
      chk("start_beats_we_hi", bus.hi, model_hi);
      chk("start_beats_we_lo", bus.lo, model_lo);
    end
    n = 0;
    while (bus.busy && n < 200) begin
      if (disturb && n == 5) begin
        bus.start     = 1'b1;
        bus.op        = 2'($urandom);
        bus.operand_a = $urandom;
        bus.operand_b = $urandom;
        bus.hi_we     = 1'b1;
        bus.lo_we     = 1'b1;
        bus.wdata     = $urandom;
      end else begin
        bus.start = 1'b0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
      end
      if (disturb && n == 7) begin
        chk("busy_we_ignored_hi", bus.hi, model_hi);
        chk("busy_we_ignored_lo", bus.lo, model_lo);
      end
      n++;
      @(negedge clk);
    end
    bus.start = 1'b0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    if (n >= 200) chk("busy_timeout", n, LAT);
    else if (chk_busy) chk("busy_cycles", n, LAT);
    model_hi = eh;
    model_lo = el;
  endtask

  // Start an op, then flush (or reset) sampled at edge E(k+1); no done may follow
  task automatic abort_op(input logic [1:0] op, input int k, input bit use_reset);
    bus.op        = op;
    bus.operand_a = $urandom;
    bus.operand_b = $urandom;
    bus.start     = 1'b1;
    @(negedge clk);
    for (int i = 0; i < k; i++) begin
      bus.start = (i == 3);
      @(negedge clk);
    end
    bus.start = 1'b0;
    if (use_reset) reset = 1'b0;
    else           bus.flush = 1'b1;
    @(negedge clk);
    reset     = 1'b1;
    bus.flush = 1'b0;
    if (use_reset) begin
      model_hi = '0;
      model_lo = '0;
      chk("reset_abort_done", bus.done,        1'b0);
      chk("reset_abort_dbz",  bus.div_by_zero, 1'b0);
    end
    chk("abort_busy", bus.busy, 1'b0);
    chk("abort_hi",   bus.hi,   model_hi);
    chk("abort_lo",   bus.lo,   model_lo);
    repeat (40) @(negedge clk);
  endtask

  initial begin
    logic [1:0]   rop;
    logic [W-1:0] ra, rb, rh, rl;
    logic         rz;
    cyc        = 0;
    compared   = 0;
    mismatched = 0;
    reset      = 1'b0;
    bus.start  = 1'b0;
    bus.op     = 2'b00;
    bus.operand_a = '0;
    bus.operand_b = '0;
    bus.flush  = 1'b0;
    bus.hi_we  = 1'b1;
    bus.lo_we  = 1'b1;
    bus.wdata  = 32'hFFFF_FFFF;
    model_hi   = '0;
    model_lo   = '0;
    repeat (3) @(negedge clk);
    chk("reset_hi",   bus.hi,          '0);
    chk("reset_lo",   bus.lo,          '0);
    chk("reset_busy", bus.busy,        1'b0);
    chk("reset_done", bus.done,        1'b0);
    chk("reset_dbz",  bus.div_by_zero, 1'b0);
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    reset     = 1'b1;
    @(negedge clk);

    // Directed operations
    run_op(2'b00, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1, 0, 0);
    run_op(2'b01, 32'hFFFF_FFFF, 32'h2, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1, 1, 0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1, 0, 0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 1, 0, 0);
    run_op(2'b11, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, 1'b1, 1, 0, 0);
    run_op(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1, 0, 1);

    // MTHI/MTLO together, then separately
    bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'h0000_CAFE;
    @(negedge clk);
    chk("mt_both_hi", bus.hi, 32'h0000_CAFE);
    chk("mt_both_lo", bus.lo, 32'h0000_CAFE);
    bus.lo_we = 1'b0; bus.wdata = 32'h0000_1234;
    @(negedge clk);
    bus.hi_we = 1'b0;
    chk("mthi_hi", bus.hi, 32'h0000_1234);
    chk("mthi_lo", bus.lo, 32'h0000_CAFE);
    model_hi = 32'h0000_1234;
    model_lo = 32'h0000_CAFE;

    // Flush at E10 with an ignored mid-flight start, then flush on the FIX edge
    abort_op(2'b01, 9, 0);
    abort_op(2'b00, W, 0);

    // Flush coincident with start in IDLE discards the start
    bus.start = 1'b1; bus.flush = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.flush = 1'b0;
    chk("flush_start_busy", bus.busy, 1'b0);
    repeat (40) @(negedge clk);

    // Reset at E5 of a DIV, then a clean MULTU
    abort_op(2'b10, 4, 1);
    run_op(2'b01, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, 1, 0, 0);

    // Randomized operations against the reference model
    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom);
      ra  = rand_val();
      rb  = rand_val();
      model(rop, ra, rb, rh, rl, rz);
      run_op(rop, ra, rb, rh, rl, rz, 1, ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0));
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
